// File: rtl/router_pkg.sv
// Shared router definitions used by the input-side and output-side arbiters.
package router_pkg;

  // Default downstream input-buffer depth in flits.
  localparam int unsigned CreditMaxDefault = 3;

  // Number of router ports competing for one output: N, E, W, S, L.
  localparam int unsigned NumPorts = 5;

  // Port indices within a request/grant vector.
  localparam logic [2:0] PortN = 3'd0;
  localparam logic [2:0] PortE = 3'd1;
  localparam logic [2:0] PortW = 3'd2;
  localparam logic [2:0] PortS = 3'd3;
  localparam logic [2:0] PortL = 3'd4;

  // One-hot arbiter state: idle or the port granted most recently.
  typedef enum logic [5:0] {
    StIdle = 6'b000001,
    StN    = 6'b000010,
    StE    = 6'b000100,
    StW    = 6'b001000,
    StS    = 6'b010000,
    StL    = 6'b100000
  } state_e;

  // State recorded after granting the given port.
  function automatic state_e port_state(input logic [2:0] idx);
    state_e s;
    case (idx)
      PortN:   s = StN;
      PortE:   s = StE;
      PortW:   s = StW;
      PortS:   s = StS;
      default: s = StL;
    endcase
    return s;
  endfunction

  // First port in the priority scan for a given state. The last granted port
  // keeps top priority; idle starts at N and invalid encodings start at L.
  function automatic logic [2:0] prio_start(input state_e s);
    logic [2:0] idx;
    case (s)
      StIdle:  idx = PortN;
      StN:     idx = PortN;
      StE:     idx = PortE;
      StW:     idx = PortW;
      StS:     idx = PortS;
      default: idx = PortL;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Downstream credit counter: one credit spent per grant, one returned per
// credit_in pulse, saturating at both ends with a sticky overflow flag.
module credit_counter
  import router_pkg::*;
#(
  parameter int unsigned CREDIT_MAX = CreditMaxDefault,
  parameter int unsigned CNT_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(CREDIT_MAX);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Next count; simultaneous dec and inc cancel out.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (dec && !inc) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - One;
      end
    end else if (inc && !dec) begin
      if (cnt_q == MaxCnt) begin
        // A credit returned while the buffer is already fully credited.
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + One;
      end
    end
  end

  // Count and error registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= MaxCnt;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt = cnt_q;
  assign err = err_q;

endmodule

// File: rtl/credit_arbiter_out.sv
// Output-port arbiter: round-robin-style priority among five input ports,
// gated by downstream buffer credits.
module credit_arbiter_out
  import router_pkg::*;
#(
  parameter int unsigned CREDIT_MAX = CreditMaxDefault,
  parameter int unsigned CNT_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_N,
  input  logic             req_E,
  input  logic             req_W,
  input  logic             req_S,
  input  logic             req_L,
  input  logic             credit_in,
  output logic             grant_N,
  output logic             grant_E,
  output logic             grant_W,
  output logic             grant_S,
  output logic             grant_L,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             credit_err
);

  state_e                state_q, state_d;
  logic [NumPorts-1:0]   req_vec;
  logic [NumPorts-1:0]   gnt_vec;
  logic                  found;
  logic [2:0]            start;
  logic [3:0]            pick;

  assign req_vec = {req_L, req_S, req_W, req_E, req_N};

  // Scan requests starting at the current priority head; first hit wins.
  always_comb begin
    gnt_vec = '0;
    state_d = state_q;
    found   = 1'b0;
    pick    = '0;
    start   = prio_start(state_q);
    if (credit_cnt != '0) begin
      for (int i = 0; i < NumPorts; i++) begin
        pick = {1'b0, start} + 4'(i);
        if (pick >= 4'(NumPorts)) begin
          pick = pick - 4'(NumPorts);
        end
        if (!found && req_vec[pick[2:0]]) begin
          found               = 1'b1;
          gnt_vec[pick[2:0]]  = 1'b1;
          state_d             = port_state(pick[2:0]);
        end
      end
    end
  end

  // Arbiter state register; reset only overrides the update, not the grants.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  credit_counter #(
    .CREDIT_MAX (CREDIT_MAX),
    .CNT_W      (CNT_W)
  ) u_credit_counter (
    .clk   (clk),
    .reset (reset),
    .dec   (|gnt_vec),
    .inc   (credit_in),
    .cnt   (credit_cnt),
    .err   (credit_err)
  );

  assign grant_N = gnt_vec[PortN];
  assign grant_E = gnt_vec[PortE];
  assign grant_W = gnt_vec[PortW];
  assign grant_S = gnt_vec[PortS];
  assign grant_L = gnt_vec[PortL];

endmodule

// File: doc/credit_arbiter_out.md
CREDIT_ARBITER_OUT -- requirements
Module: credit_arbiter_out

Interface
REQ-001 The block SHALL have parameter CREDIT_MAX, default 3, meaning the downstream input-buffer depth in flits (range 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 2, meaning the credit-counter width; CNT_W SHALL be at least ceil(log2(CREDIT_MAX+1)).
REQ-003 The block SHALL have port clk  in  1  the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have ports req_N, req_E, req_W, req_S, req_L  in  1 each  requests from the five input-port arbiters for this output.
REQ-006 The block SHALL have port credit_in  in  1  a one-cycle pulse per freed downstream buffer slot.
REQ-007 The block SHALL have ports grant_N, grant_E, grant_W, grant_S, grant_L  out  1 each  one-hot-or-zero grants; each grant cycle transfers one flit.
REQ-008 The block SHALL have port credit_cnt  out  CNT_W  the current registered credit count.
REQ-009 The block SHALL have port credit_err  out  1  sticky credit-overflow flag.

Function
REQ-010 The block SHALL hold a registered one-hot state in {IDLE, N, E, W, S, L}, encoded 6'b000001, 000010, 000100, 001000, 010000, 100000 respectively.
REQ-011 Grants SHALL be combinational from the registered state, the current req_* inputs and the registered credit_cnt, with zero-cycle latency.
REQ-012 When credit_cnt == 0, all grants SHALL be 0 and the state SHALL hold, regardless of the requests.
REQ-013 When credit_cnt > 0, the block SHALL grant the highest-priority active request; the priority order SHALL be as follows:
- IDLE: N, E, W, S, L
- N: N, E, W, S, L
- E: E, W, S, L, N
- W: W, S, L, N, E
- S: S, L, N, E, W
- L or any invalid encoding: L, N, E, W, S
REQ-014 On a grant, the next state SHALL be the granted port; with no active request, the state SHALL hold.
REQ-015 At most one grant SHALL be high in any cycle.
REQ-016 The next credit count SHALL be credit_cnt − (any grant) + credit_in.
REQ-017 When a grant and credit_in occur in the same cycle, credit_cnt SHALL be unchanged.
REQ-018 When credit_in=1, no grant is issued and credit_cnt == CREDIT_MAX:
- credit_cnt SHALL stay at CREDIT_MAX
- credit_err SHALL be set the next cycle and remain set until reset
REQ-019 A grant issued at credit_cnt == 1 with no credit_in SHALL make credit_cnt 0 the next cycle, blocking grants from that cycle onward.
REQ-020 credit_cnt SHALL never wrap below 0 or above CREDIT_MAX.

Reset
REQ-021 While reset==0 at a clock edge, the next register values SHALL be state=IDLE, credit_cnt=CREDIT_MAX and credit_err=0.
REQ-022 During any cycle with reset==0, the grants SHALL still be evaluated from the current registered values; only register updates SHALL be overridden.
REQ-023 Reset asserted mid-transfer SHALL discard the in-flight accounting; no credit is retained across reset.

Structure
REQ-024 The six one-hot state constants and the default CREDIT_MAX SHALL reside in a shared router package used by both input-side and output-side arbiters.
REQ-025 Credit accounting SHALL be a sub-module, credit_counter, with ports:
- inputs: clk, reset, dec, inc
- outputs: cnt, err
REQ-026 The arbitration FSM SHALL remain in credit_arbiter_out.

Verification
REQ-027 Reset, then hold req_E=1 with credit_in=0: grant_E SHALL be high for exactly 3 cycles, credit_cnt SHALL go 3,2,1,0, then all grants SHALL be 0 and the state SHALL remain E.
REQ-028 With the state at S and credit_cnt=3, set req_N=req_L=1: grant_L=1 and the next state SHALL be L; then drop req_L: grant_N=1.
REQ-029 With credit_cnt=0 and req_W=1, pulse credit_in for one cycle: the next cycle credit_cnt=1 and grant_W=1; the cycle after, credit_cnt=0.
REQ-030 With credit_cnt=2, drive req_N=1 and credit_in=1 for 4 cycles: grant_N SHALL be high every cycle and credit_cnt SHALL remain 2.
REQ-031 With credit_cnt=3, no requests and a credit_in pulse: credit_cnt SHALL stay 3 and credit_err=1 the next cycle; credit_err SHALL stay 1 until reset=0, then return to 0.
REQ-032 Assert reset=0 while credit_cnt=1 and in state W: after the edge, state=IDLE, credit_cnt=3, and with req_N=req_W=1, grant_N=1.
